gauss5x5_stream: RTL and testbench

//  Streaming 5x5 Gaussian blur over a raster-order image.
//  All NUM_CH colour channels arrive in parallel, one pixel per accepted beat.

---
 rtl/gauss5x5_stream_pkg.sv | 21 ++
 rtl/gauss5x5_stream_if.sv | 24 ++
 rtl/gauss5x5_stream_core.sv | 66 ++++++
 rtl/gauss5x5_stream.sv | 113 +++++++++++
 tb/tb_gauss5x5_stream.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/gauss5x5_stream_pkg.sv
// rtl/gauss5x5_stream_pkg.sv - kernel constants and helpers for the 5x5 Gaussian blur
package gauss_pkg;

    localparam int W5 [5][5] = '{
        '{2,  4,  5,  4, 2},
        '{4,  9, 12,  9, 4},
        '{5, 12, 15, 12, 5},
        '{4,  9, 12,  9, 4},
        '{2,  4,  5,  4, 2}
    };
    localparam int KSUM     = 159;
    localparam int RECIP    = 412;
    localparam int RECIP_SH = 16;

    function automatic logic [31:0] sat_pix(input logic [31:0] v, input int pix_w);
        logic [31:0] mx;
        mx = (32'd1 << pix_w) - 32'd1;
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/gauss5x5_stream_if.sv
// rtl/gauss5x5_stream_if.sv - pixel stream in/out bundle for gauss5x5_stream
interface gauss5x5_stream_if #(
    parameter int PIX_W  = 8,
    parameter int NUM_CH = 3
);
    logic                      i_valid;
    logic                      i_sof;
    logic                      i_bypass;
    logic [NUM_CH*PIX_W-1:0]   i_pixel;
    logic                      o_valid;
    logic                      o_row_end;
    logic                      o_frame_end;
    logic [NUM_CH*PIX_W-1:0]   o_pixel;

    modport master (
        output i_valid, i_sof, i_bypass, i_pixel,
        input  o_valid, o_row_end, o_frame_end, o_pixel
    );

    modport slave (
        input  i_valid, i_sof, i_bypass, i_pixel,
        output o_valid, o_row_end, o_frame_end, o_pixel
    );
endinterface

// File: rtl/gauss5x5_stream_core.sv
// rtl/gauss5x5_stream_core.sv - one channel: column sums (stage1), total, reciprocal scale, bypass (stage2)
module gauss5_core
    import gauss_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [25*PIX_W-1:0]  i_win,
    input  logic                 i_bypass,
    output logic [PIX_W-1:0]     o_pix
);
    localparam int SW  = PIX_W + 8;
    localparam int PW2 = SW + 10;

    logic [SW-1:0]    col_sum_d [5];
    logic [SW-1:0]    col_sum_q [5];
    logic             s1_bypass;
    logic [PIX_W-1:0] s1_centre;
    logic [SW-1:0]    total;
    logic [PW2-1:0]   prod_rnd;
    logic [PIX_W-1:0] blur_pix;

    // Constant weights expand into shifted adds; no multipliers are inferred.
    always_comb begin
        for (int j = 0; j < 5; j++) begin
            col_sum_d[j] = '0;
            for (int i = 0; i < 5; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (((W5[i][j] >> b) & 1) != 0)
                        col_sum_d[j] = col_sum_d[j] + (SW'(i_win[(i*5+j)*PIX_W +: PIX_W]) << b);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < 5; j++) col_sum_q[j] <= '0;
            s1_bypass <= 1'b0;
            s1_centre <= '0;
        end else begin
            for (int j = 0; j < 5; j++) col_sum_q[j] <= col_sum_d[j];
            s1_bypass <= i_bypass;
            s1_centre <= i_win[12*PIX_W +: PIX_W];
        end
    end

    // Divide by 159 as multiply by 412/65536 with round-half-up.
    always_comb begin
        total = '0;
        for (int j = 0; j < 5; j++) total = total + col_sum_q[j];
        prod_rnd = PW2'(1 << (RECIP_SH - 1));
        for (int b = 0; b < 10; b++) begin
            if (((RECIP >> b) & 1) != 0)
                prod_rnd = prod_rnd + (PW2'(total) << b);
        end
        blur_pix = PIX_W'(sat_pix(32'(prod_rnd >> RECIP_SH), PIX_W));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_pix <= '0;
        else          o_pix <= s1_bypass ? s1_centre : blur_pix;
    end

endmodule

// File: rtl/gauss5x5_stream.sv
// rtl/gauss5x5_stream.sv - streaming 5x5 Gaussian blur: counters, line buffer, window, per-channel cores
module gauss5x5_stream
    import gauss_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int NUM_CH     = 3,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    gauss5x5_stream_if.slave  s
);
    localparam int PXW = NUM_CH * PIX_W;
    localparam int CW  = $clog2(IMG_WIDTH);
    localparam int RW  = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          col_last, row_last;

    logic [3:0][PXW-1:0] lb [IMG_WIDTH];
    logic [3:0][PXW-1:0] lb_rd;
    logic [PXW-1:0]      win [5][5];

    logic s0_valid, s0_bypass, s0_row_end, s0_frame_end;
    logic s1_valid, s1_row_end, s1_frame_end;
    logic s2_valid, s2_row_end, s2_frame_end;
    logic [PXW-1:0] pix_out;

    // A start-of-frame beat is pixel (0,0) regardless of where the counters were.
    always_comb begin
        cur_col  = s.i_sof ? '0 : col;
        cur_row  = s.i_sof ? '0 : row;
        col_last = (cur_col == CW'(IMG_WIDTH - 1));
        row_last = (cur_row == RW'(IMG_HEIGHT - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col <= '0;
            row <= '0;
        end else if (s.i_valid) begin
            col <= col_last ? '0 : cur_col + 1'b1;
            row <= col_last ? (row_last ? '0 : cur_row + 1'b1) : cur_row;
        end
    end

    // Slot 0 is the oldest row (r-4), slot 3 is r-1; read-before-write shifts one row up.
    assign lb_rd = lb[cur_col];

    always_ff @(posedge i_clk) begin
        if (s.i_valid) lb[cur_col] <= {s.i_pixel, lb_rd[3], lb_rd[2], lb_rd[1]};
    end

    always_ff @(posedge i_clk) begin
        if (s.i_valid) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 4; j++)
                    win[i][j] <= win[i][j+1];
            for (int i = 0; i < 4; i++) win[i][4] <= lb_rd[i];
            win[4][4] <= s.i_pixel;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_valid     <= 1'b0;
            s0_bypass    <= 1'b0;
            s0_row_end   <= 1'b0;
            s0_frame_end <= 1'b0;
            s1_valid     <= 1'b0;
            s1_row_end   <= 1'b0;
            s1_frame_end <= 1'b0;
            s2_valid     <= 1'b0;
            s2_row_end   <= 1'b0;
            s2_frame_end <= 1'b0;
        end else begin
            s0_valid     <= s.i_valid && (cur_col >= CW'(4)) && (cur_row >= RW'(4));
            s0_bypass    <= s.i_bypass;
            s0_row_end   <= col_last;
            s0_frame_end <= col_last && row_last;
            s1_valid     <= s0_valid;
            s1_row_end   <= s0_valid && s0_row_end;
            s1_frame_end <= s0_valid && s0_frame_end;
            s2_valid     <= s1_valid;
            s2_row_end   <= s1_row_end;
            s2_frame_end <= s1_frame_end;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [25*PIX_W-1:0] wf;
        for (genvar i = 0; i < 5; i++) begin : g_r
            for (genvar j = 0; j < 5; j++) begin : g_c
                assign wf[(i*5+j)*PIX_W +: PIX_W] = win[i][j][ch*PIX_W +: PIX_W];
            end
        end
        gauss5_core #(.PIX_W(PIX_W)) u_core (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_win    (wf),
            .i_bypass (s0_bypass),
            .o_pix    (pix_out[ch*PIX_W +: PIX_W])
        );
    end

    assign s.o_valid     = s2_valid;
    assign s.o_row_end   = s2_row_end;
    assign s.o_frame_end = s2_frame_end;
    assign s.o_pixel     = pix_out;

endmodule

// File: tb/tb_gauss5x5_stream.sv
// tb/tb_gauss5x5_stream.sv - scoreboard bench for gauss5x5_stream with a frame-level reference model
module tb_gauss5x5_stream;
    localparam int PIX_W = 8;
    localparam int NC    = 3;
    localparam int W     = 8;
    localparam int H     = 6;
    localparam int PW    = NC * PIX_W;
    localparam int KW [5][5] = '{
        '{2, 4, 5, 4, 2}, '{4, 9, 12, 9, 4}, '{5, 12, 15, 12, 5},
        '{4, 9, 12, 9, 4}, '{2, 4, 5, 4, 2}};

    typedef struct {
        logic [PW-1:0] pix;
        logic          re;
        logic          fe;
        int            edge_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gauss5x5_stream_if #(.PIX_W(PIX_W), .NUM_CH(NC)) bus ();
    gauss5x5_stream #(.PIX_W(PIX_W), .NUM_CH(NC), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s       (bus)
    );

    exp_t          sbq [$];
    exp_t          mon_e;
    logic [PW-1:0] obs [$];
    logic [PW-1:0] ref_obs [$];
    logic [PW-1:0] fr [H][W];
    int            mimg [H][W][NC];
    int            mc, mr;
    int            checks = 0, failures = 0;
    int            edge_cnt = 0;
    int            n_out = 0, n_re = 0, n_fe = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected output for the beat at (r,c): centre (r-2,c-2) of the image seen so far.
    function automatic logic [PW-1:0] model_out(input int r, input int c, input bit byp);
        logic [PW-1:0] res;
        int s, v;
        for (int ch = 0; ch < NC; ch++) begin
            if (byp) v = mimg[r-2][c-2][ch];
            else begin
                s = 0;
                for (int dy = 0; dy < 5; dy++)
                    for (int dx = 0; dx < 5; dx++)
                        s += KW[dy][dx] * mimg[r-4+dy][c-4+dx][ch];
                v = (s * 412 + 32768) >>> 16;
                if (v > 255) v = 255;
            end
            res[ch*PIX_W +: PIX_W] = 8'(v);
        end
        return res;
    endfunction

    always @(posedge clk) begin
        #1;
        if (bus.o_valid === 1'b1) begin
            n_out++;
            if (bus.o_row_end === 1'b1) n_re++;
            if (bus.o_frame_end === 1'b1) n_fe++;
            obs.push_back(bus.o_pixel);
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h expected=none t=%0t", bus.o_pixel, $time);
            end else begin
                mon_e = sbq.pop_front();
                check("pixel", 32'(bus.o_pixel), 32'(mon_e.pix));
                check("row_end", 32'(bus.o_row_end), 32'(mon_e.re));
                check("frame_end", 32'(bus.o_frame_end), 32'(mon_e.fe));
                check("latency_edge", 32'(edge_cnt), 32'(mon_e.edge_n + 2));
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        bus.i_valid  = 1'b0;
        bus.i_sof    = 1'b0;
        bus.i_bypass = 1'($urandom);
        bus.i_pixel  = PW'($urandom);
    endtask

    task automatic send(input logic [PW-1:0] p, input bit sof, input bit byp);
        exp_t e;
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_sof    = sof;
        bus.i_bypass = byp;
        bus.i_pixel  = p;
        if (sof) begin mc = 0; mr = 0; end
        for (int ch = 0; ch < NC; ch++) mimg[mr][mc][ch] = int'(p[ch*PIX_W +: PIX_W]);
        if (mc >= 4 && mr >= 4) begin
            e.pix    = model_out(mr, mc, byp);
            e.re     = (mc == W - 1);
            e.fe     = (mc == W - 1) && (mr == H - 1);
            e.edge_n = edge_cnt + 1;
            sbq.push_back(e);
        end
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else mc++;
    endtask

    task automatic send_frame(input bit byp, input int gap_pct, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            while (int'($urandom_range(99)) < gap_pct) idle();
            send(fr[k / W][k % W], k == 0, byp);
        end
    endtask

    task automatic drain(input string name);
        repeat (4) idle();
        check(name, 32'(sbq.size()), 32'd0);
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: fr[r][c] = 24'h646464;
                    1: fr[r][c] = (r == 2 && c == 2) ? 24'h0000FF : 24'h0;
                    2: fr[r][c] = 24'hFFFFFF;
                    3: fr[r][c] = {8'(r*8+c+100), 8'(r*8+c+50), 8'(r*8+c)};
                    default: fr[r][c] = PW'($urandom);
                endcase
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_sof = 1'b0; bus.i_bypass = 1'b0; bus.i_pixel = '0;
        mc = 0; mr = 0;
        repeat (3) @(negedge clk);
        check("reset_o_valid", 32'(bus.o_valid), 32'd0);
        check("reset_o_row_end", 32'(bus.o_row_end), 32'd0);
        check("reset_o_frame_end", 32'(bus.o_frame_end), 32'd0);
        check("reset_o_pixel", 32'(bus.o_pixel), 32'd0);
        rst_n = 1'b1;

        fill(0);
        n_out = 0; n_re = 0; n_fe = 0;
        send_frame(0, 0, W * H);
        drain("flat_drain");
        check("flat_count", 32'(n_out), 32'd8);
        check("flat_row_ends", 32'(n_re), 32'd2);
        check("flat_frame_ends", 32'(n_fe), 32'd1);

        fill(1);
        obs.delete();
        send_frame(0, 0, W * H);
        drain("impulse_drain");
        check("impulse_count", 32'(obs.size()), 32'd8);
        if (obs.size() > 0) begin
            check("impulse_ch0", 32'(obs[0][7:0]), 32'd24);
            check("impulse_ch12", 32'(obs[0][23:8]), 32'd0);
        end

        fill(2);
        send_frame(0, 0, W * H);
        drain("sat_drain");

        fill(3);
        send_frame(1, 0, W * H);
        drain("bypass_drain");

        fill(4);
        obs.delete();
        send_frame(0, 0, W * H);
        drain("rand_drain");
        ref_obs = obs;
        obs.delete();
        send_frame(0, 50, W * H);
        drain("gap_drain");
        check("gap_count", 32'(obs.size()), 32'(ref_obs.size()));
        for (int i = 0; i < obs.size() && i < ref_obs.size(); i++)
            check("gap_vs_nogap", 32'(obs[i]), 32'(ref_obs[i]));

        fill(4);
        send_frame(0, 0, 3 * W + 5);
        fill(4);
        send_frame(0, 0, W * H);
        drain("midsof_drain");

        fill(4);
        send_frame(0, 0, 5 * W + 6);
        fill(4);
        send_frame(0, 0, W * H);
        drain("inflight_sof_drain");

        fill(4);
        send_frame(0, 0, 4 * W + 6);
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        sbq.delete();
        #1;
        check("midreset_o_valid", 32'(bus.o_valid), 32'd0);
        check("midreset_o_pixel", 32'(bus.o_pixel), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mc = 0; mr = 0;
        fill(4);
        send_frame(0, 25, W * H);
        drain("restart_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
